// File: rtl/seq_mult_controller.sv
// seq_mult_controller: load/add/shift sequencer for a WIDTH x WIDTH shift-add multiplier (optional EARLY_EXIT_EN)
module seq_mult_controller #(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             q0,
    input  logic             mplr_zero,
    output logic             sig_rst,
    output logic             ld1,
    output logic             ld2,
    output logic             add_en,
    output logic             shift,
    output logic             busy,
    output logic             ready,
    output logic             done,
    output logic [CNT_W-1:0] iter
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4,
        HOLD  = 3'd5
    } state_t;

    state_t state, nxt;
    logic   early;

`ifdef EARLY_EXIT_EN
    assign early = mplr_zero;
`else
    logic unused_mplr;
    assign unused_mplr = mplr_zero;
    assign early = 1'b0;
`endif

    // add decision is the only Mealy output: it follows q0 within the ADD cycle
    assign add_en = (state == ADD) && q0 && !early;

    // next-state selection; unused codes fall back to IDLE
    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = start ? LOAD : IDLE;
            LOAD:    nxt = ADD;
            ADD:     nxt = early ? DONE : SHIFT;
            SHIFT:   nxt = (iter == CNT_W'(WIDTH - 1)) ? DONE : ADD;
            DONE:    nxt = start ? HOLD : IDLE;
            HOLD:    nxt = start ? HOLD : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // state, iteration count and the state-decoded outputs, registered from the next state
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            iter    <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            sig_rst <= 1'b0;
            ld1     <= 1'b0;
            ld2     <= 1'b0;
            shift   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= nxt;
            iter    <= (state == LOAD) ? '0 : (state == SHIFT) ? iter + CNT_W'(1) : iter;
            ready   <= nxt == IDLE;
            busy    <= nxt == LOAD || nxt == ADD || nxt == SHIFT;
            sig_rst <= nxt == LOAD;
            ld1     <= nxt == LOAD;
            ld2     <= nxt == LOAD;
            shift   <= nxt == SHIFT;
            done    <= nxt == DONE;
        end
    end
endmodule

// File: tb/tb_seq_mult_controller.sv
// tb_seq_mult_controller: directed vector table plus multi-cycle corner sequences for WIDTH=4 and WIDTH=8
module tb_seq_mult_controller;
    logic clk = 1'b0;
    logic clr = 1'b0;
    logic start = 1'b0, q0 = 1'b0, mz = 1'b0;
    logic start8 = 1'b0, q0_8 = 1'b1, mz8 = 1'b0;
    logic sig_rst, ld1, ld2, add_en, shift, busy, ready, done;
    logic sig_rst8, ld1_8, ld2_8, add_en8, shift8, busy8, ready8, done8;
    logic [2:0] iter4;
    logic [3:0] iter8;
    logic [7:0] o4;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    seq_mult_controller #(.WIDTH(4)) u4 (
        .clk(clk), .clr(clr), .start(start), .q0(q0), .mplr_zero(mz),
        .sig_rst(sig_rst), .ld1(ld1), .ld2(ld2), .add_en(add_en), .shift(shift),
        .busy(busy), .ready(ready), .done(done), .iter(iter4)
    );

    seq_mult_controller #(.WIDTH(8)) u8 (
        .clk(clk), .clr(clr), .start(start8), .q0(q0_8), .mplr_zero(mz8),
        .sig_rst(sig_rst8), .ld1(ld1_8), .ld2(ld2_8), .add_en(add_en8), .shift(shift8),
        .busy(busy8), .ready(ready8), .done(done8), .iter(iter8)
    );

    assign o4 = {ready, busy, sig_rst, ld1, ld2, add_en, shift, done};

    localparam logic [7:0] R  = 8'b1000_0000;
    localparam logic [7:0] LD = 8'b0111_1000;
    localparam logic [7:0] A  = 8'b0100_0100;
    localparam logic [7:0] B  = 8'b0100_0000;
    localparam logic [7:0] S  = 8'b0100_0010;
    localparam logic [7:0] D  = 8'b0000_0001;

    typedef struct {
        logic       st;
        logic       q;
        logic [7:0] o;
        logic [2:0] it;
    } vec_t;

    vec_t v[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // start pulse, then run until done; q0=1 throughout, mplr_zero only in cycle mz_at
    task automatic run4(input int mz_at, output int edges, output int adds,
                        output int shifts, output int add_at, output int it);
        edges = -1; adds = 0; shifts = 0; add_at = -1; it = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            q0 = 1'b1;
            mz = (n == mz_at);
            #1;
            adds += int'(add_en);
            shifts += int'(shift);
            if (n == mz_at) add_at = int'(add_en);
            if (done) begin
                edges = n;
                it = int'(iter4);
                break;
            end
            @(posedge clk); #1;
        end
        mz = 1'b0;
    endtask

    initial begin
        int e, a, s, aa, it, lds, adds8, n;
        v[0]  = '{1'b1, 1'b0, R,  3'd0};
        v[1]  = '{1'b0, 1'b0, LD, 3'd0};
        v[2]  = '{1'b0, 1'b1, A,  3'd0};
        v[3]  = '{1'b0, 1'b1, S,  3'd0};
        v[4]  = '{1'b0, 1'b1, A,  3'd1};
        v[5]  = '{1'b0, 1'b1, S,  3'd1};
        v[6]  = '{1'b0, 1'b0, B,  3'd2};
        v[7]  = '{1'b0, 1'b1, S,  3'd2};
        v[8]  = '{1'b0, 1'b1, A,  3'd3};
        v[9]  = '{1'b0, 1'b1, S,  3'd3};
        v[10] = '{1'b0, 1'b0, D,  3'd4};
        v[11] = '{1'b0, 1'b0, R,  3'd4};

        #1 clr = 1'b1;
        #1;
        chk("reset_outputs", int'(o4), int'(R));
        chk("reset_iter", int'(iter4), 0);
        chk("reset_ready8", int'({ready8, busy8, done8, ld1_8}), 8);
        @(negedge clk) clr = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 12; k++) begin
            start = v[k].st;
            q0 = v[k].q;
            #1;
            chk($sformatf("vec%0d", k), int'({o4, iter4}), int'({v[k].o, v[k].it}));
            @(posedge clk); #1;
        end

        start = 1'b1;
        @(posedge clk); #1;
        e = -1;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (done) begin
                e = k;
                break;
            end
            @(posedge clk); #1;
        end
        chk("held_done_edge", e, 9);
        @(posedge clk); #1;
        chk("hold_outputs", int'(o4), 0);
        @(posedge clk); #1;
        chk("hold_no_reload", int'(o4), 0);
        start = 1'b0;
        @(posedge clk); #1;
        chk("hold_release_ready", int'(o4), int'(R));

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 0;
        for (int k = 0; k < 6; k++) begin
            a += int'(done);
            @(posedge clk); #1;
        end
        chk("abort_in_shift2", int'(o4), int'(S));
        #2 clr = 1'b1;
        #1;
        chk("abort_outputs", int'(o4), int'(R));
        chk("abort_iter", int'(iter4), 0);
        chk("abort_no_done", a, 0);
        @(negedge clk) clr = 1'b0;
        @(posedge clk); #1;
        run4(-1, e, a, s, aa, it);
        chk("rerun_done_edge", e, 9);
        chk("rerun_iter", it, 4);
        chk("rerun_adds", a, 4);
        chk("rerun_shifts", s, 4);
        @(posedge clk); #1;
        chk("rerun_ready", int'(o4), int'(R));

        run4(3, e, a, s, aa, it);
`ifdef EARLY_EXIT_EN
        chk("early_done_edge", e, 4);
        chk("early_iter", it, 1);
        chk("early_add_in_add1", aa, 0);
        chk("early_adds", a, 1);
        chk("early_shifts", s, 1);
`else
        chk("noearly_done_edge", e, 9);
        chk("noearly_iter", it, 4);
        chk("noearly_add_in_add1", aa, 1);
        chk("noearly_adds", a, 4);
        chk("noearly_shifts", s, 4);
`endif
        @(posedge clk); #1;
        chk("after_mz_ready", int'(o4), int'(R));

        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        e = -1; lds = 0; adds8 = 0; n = 0;
        for (int k = 0; k < 60; k++) begin
            start8 = (k == 5 || k == 6);
            #1;
            lds += int'(ld1_8);
            adds8 += int'(add_en8);
            if (done8) begin
                e = k;
                break;
            end
            @(posedge clk); #1;
        end
        start8 = 1'b0;
        chk("w8_done_edge", e, 17);
        chk("w8_iter", int'(iter8), 8);
        chk("w8_single_load", lds, 1);
        chk("w8_adds", adds8, 8);
        @(posedge clk); #1;
        chk("w8_ready", int'({ready8, busy8, done8}), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
